spi_kb_rx: RTL and testbench

Receive-only SPI slave deserializer (mode 0, MSB first) that turns the external keyboard controller's serial stream into parallel bytes. It sits directly upstream of `keyboard_buf`: its `rx_data`/`rx_done` outputs drive that block's `rx_data`/`rx_done` inputs. All SPI pins are asynchronous to `clk`. The block synchronizes them, detects `sclk` edges, and emits each completed byte with a one-cycle strobe.

---
 rtl/spi_kb_rx.sv | 124 ++++++++++++
 tb/tb_spi_kb_rx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_kb_rx.sv
// Receive-only SPI slave (mode 0, MSB first) for the keyboard controller link.
// Synchronizes the async SPI pins, detects sclk rises and emits completed bytes with a one-cycle strobe.
module spi_kb_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int BITS        = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            spi_sclk,
  input  logic            spi_mosi,
  input  logic            spi_cs_n,
  output logic [BITS-1:0] rx_data,
  output logic            rx_done,
  output logic            rx_busy,
  output logic            frame_err
);

  localparam int CNT_W = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic                   sclk_prev_q;

  logic sclk_s;
  logic mosi_s;
  logic cs_n_s;
  logic sclk_rise;

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
  logic [BITS-1:0]  shreg_q,     shreg_d;
  logic [BITS-1:0]  rx_data_q,   rx_data_d;
  logic             rx_done_q,   rx_done_d;
  logic             frame_err_q, frame_err_d;
  logic [BITS-1:0]  shifted;

  // Deselected pins idle as sclk low and cs_n high, so the chains reset to that.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sclk_prev_q <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_n_s    = cs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign shifted   = {shreg_q[BITS-2:0], mosi_s};

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!cs_n_s) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end
      end
      SHIFT: begin
        // Deselect takes priority over a coincident sclk rise; a partial byte is dropped.
        if (cs_n_s) begin
          state_d     = IDLE;
          frame_err_d = (bit_cnt_q != '0);
        end else if (sclk_rise) begin
          shreg_d   = shifted;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            rx_data_d = shifted;
            rx_done_d = 1'b1;
            bit_cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign rx_busy   = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_kb_rx.sv
// Directed testbench for spi_kb_rx: reset, single byte, burst, abort, collision and mid-byte reset.
// SPI pins are driven on falling clk edges; outputs are sampled on falling edges as well.
module tb_spi_kb_rx;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 4;   // sclk phase in clk cycles (f_clk/8)

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_sclk;
  logic       spi_mosi;
  logic       spi_cs_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       frame_err;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int last_rise_cyc;
  int err_cnt      = 0;
  logic [7:0] done_data[$];
  int         done_cyc[$];

  spi_kb_rx #(.SYNC_STAGES(SYNC_STAGES), .BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_cs_n  (spi_cs_n),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_busy   (rx_busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_done === 1'b1) begin
      done_data.push_back(rx_data);
      done_cyc.push_back(cyc);
    end
    if (frame_err === 1'b1) err_cnt = err_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "timeout");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    done_data.delete();
    done_cyc.delete();
    err_cnt = 0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    spi_cs_n = 1'b0;
    wait_cycles(4);
  endtask

  task automatic cs_high();
    @(negedge clk);
    spi_cs_n = 1'b1;
    wait_cycles(6);
  endtask

  // Shift the top nbits of b, MSB first; sclk low then high, each HALF cycles.
  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      spi_sclk = 1'b0;
      spi_mosi = b[7-i];
      wait_cycles(HALF);
      spi_sclk      = 1'b1;
      last_rise_cyc = cyc;
      wait_cycles(HALF - 1);
    end
    @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      spi_sclk = ~spi_sclk;
      spi_mosi = ~spi_mosi;
      spi_cs_n = ~spi_cs_n;
      tests_run++;
      if (rx_data !== 8'h00 || rx_busy !== 1'b0 || rx_done !== 1'b0 || frame_err !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hold[%0d]: data=%h busy=%b done=%b err=%b, want 00/0/0/0",
                 i, rx_data, rx_busy, rx_done, frame_err);
      end
    end
    @(negedge clk);
    spi_cs_n = 1'b1;
    spi_sclk = 1'b0;
    rst_n    = 1'b1;
    clear_log();
    wait_cycles(6);
    tests_run++;
    if (rx_busy !== 1'b0 || done_data.size() != 0 || err_cnt != 0) begin
      tests_failed++;
      $display("FAIL reset_release: busy=%b dones=%0d errs=%0d, want 0/0/0",
               rx_busy, done_data.size(), err_cnt);
    end
  endtask

  task automatic test_single_byte();
    int exp_cyc;
    clear_log();
    cs_low();
    tests_run++;
    if (rx_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_busy: got %b want 1", rx_busy);
    end
    send_bits(8'h68, 8);
    exp_cyc = last_rise_cyc + 1 + SYNC_STAGES;
    cs_high();
    tests_run++;
    if (done_data.size() != 1) begin
      tests_failed++;
      $display("FAIL single_count: got %0d pulses want 1", done_data.size());
    end else begin
      if (done_data[0] !== 8'h68) begin
        tests_failed++;
        $display("FAIL single_data: got %h want 68", done_data[0]);
      end
      tests_run++;
      if (done_cyc[0] != exp_cyc) begin
        tests_failed++;
        $display("FAIL single_latency: rx_done at cycle %0d want %0d", done_cyc[0], exp_cyc);
      end
    end
    tests_run++;
    if (err_cnt != 0 || rx_busy !== 1'b0 || rx_data !== 8'h68) begin
      tests_failed++;
      $display("FAIL single_end: errs=%0d busy=%b data=%h, want 0/0/68", err_cnt, rx_busy, rx_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [5];
    bytes = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    clear_log();
    cs_low();
    for (int i = 0; i < 5; i++) begin
      send_bits(bytes[i], 8);
      tests_run++;
      if (rx_busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL burst_busy[%0d]: got %b want 1", i, rx_busy);
      end
    end
    wait_cycles(4);
    cs_high();
    tests_run++;
    if (done_data.size() != 5 || err_cnt != 0) begin
      tests_failed++;
      $display("FAIL burst_count: got %0d pulses %0d errs, want 5/0", done_data.size(), err_cnt);
    end
    for (int i = 0; i < 5 && i < done_data.size(); i++) begin
      tests_run++;
      if (done_data[i] !== bytes[i]) begin
        tests_failed++;
        $display("FAIL burst_data[%0d]: got %h want %h", i, done_data[i], bytes[i]);
      end
    end
  endtask

  task automatic test_abort();
    clear_log();
    cs_low();
    send_bits(8'hA5, 5);
    wait_cycles(2);
    cs_high();
    tests_run++;
    if (err_cnt != 1 || done_data.size() != 0 || rx_data !== 8'h6F) begin
      tests_failed++;
      $display("FAIL abort: errs=%0d dones=%0d data=%h, want 1/0/6F",
               err_cnt, done_data.size(), rx_data);
    end
    clear_log();
    cs_low();
    send_bits(8'h20, 8);
    wait_cycles(2);
    cs_high();
    tests_run++;
    if (done_data.size() != 1 || rx_data !== 8'h20 || err_cnt != 0) begin
      tests_failed++;
      $display("FAIL abort_recover: dones=%0d data=%h errs=%0d, want 1/20/0",
               done_data.size(), rx_data, err_cnt);
    end
  endtask

  task automatic test_collision();
    clear_log();
    cs_low();
    send_bits(8'hC3, 7);
    @(negedge clk);
    spi_mosi = 1'b1;
    wait_cycles(HALF);
    spi_sclk = 1'b1;
    spi_cs_n = 1'b1;
    wait_cycles(HALF + 4);
    spi_sclk = 1'b0;
    wait_cycles(4);
    tests_run++;
    if (done_data.size() != 0 || err_cnt != 1 || rx_data !== 8'h20 || rx_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL collision: dones=%0d errs=%0d data=%h busy=%b, want 0/1/20/0",
               done_data.size(), err_cnt, rx_data, rx_busy);
    end
    clear_log();
    send_bits(8'hFF, 8);
    send_bits(8'h00, 3);
    tests_run++;
    if (done_data.size() != 0 || err_cnt != 0 || rx_busy !== 1'b0 || rx_data !== 8'h20) begin
      tests_failed++;
      $display("FAIL ignored_edges: dones=%0d errs=%0d busy=%b data=%h, want 0/0/0/20",
               done_data.size(), err_cnt, rx_busy, rx_data);
    end
    cs_low();
    send_bits(8'h55, 8);
    wait_cycles(2);
    cs_high();
    tests_run++;
    if (done_data.size() != 1 || rx_data !== 8'h55 || err_cnt != 0) begin
      tests_failed++;
      $display("FAIL after_ignored: dones=%0d data=%h errs=%0d, want 1/55/0",
               done_data.size(), rx_data, err_cnt);
    end
  endtask

  task automatic test_reset_mid_byte();
    clear_log();
    cs_low();
    send_bits(8'h77, 4);
    @(negedge clk);
    rst_n    = 1'b0;
    spi_cs_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (rx_data !== 8'h00 || rx_busy !== 1'b0 || rx_done !== 1'b0 || frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_hold: data=%h busy=%b done=%b err=%b, want 00/0/0/0",
               rx_data, rx_busy, rx_done, frame_err);
    end
    rst_n = 1'b1;
    wait_cycles(6);
    tests_run++;
    if (done_data.size() != 0 || err_cnt != 0 || rx_busy !== 1'b0 || rx_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL midreset_after: dones=%0d errs=%0d busy=%b data=%h, want 0/0/0/00",
               done_data.size(), err_cnt, rx_busy, rx_data);
    end
    cs_low();
    send_bits(8'h77, 8);
    wait_cycles(2);
    cs_high();
    tests_run++;
    if (done_data.size() != 1 || rx_data !== 8'h77 || err_cnt != 0) begin
      tests_failed++;
      $display("FAIL midreset_frame: dones=%0d data=%h errs=%0d, want 1/77/0",
               done_data.size(), rx_data, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_abort();
    test_collision();
    test_reset_mid_byte();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
